// File: rtl/pwm_audio_out.sv
// pwm_audio_out: 8-bit sample PWM audio output with a stepped 0..16 gain fade
// between full volume and silence, driven by a level mute request.
module pwm_audio_out #(
  parameter int unsigned FADE_STEP_PERIODS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sample_in,
  input  logic       mute,
  output logic       pwm_out,
  output logic       sample_strobe,
  output logic       muted
);

  typedef enum logic [1:0] {
    MUTED    = 2'd0,
    FADE_IN  = 2'd1,
    PLAY     = 2'd2,
    FADE_OUT = 2'd3
  } state_t;

  localparam logic [7:0] STEP_LAST = 8'(FADE_STEP_PERIODS - 1);

  logic [7:0]         cnt;
  logic [7:0]         duty;
  logic [7:0]         step_cnt;
  logic [4:0]         gain;
  state_t             state;
  logic               boundary;
  logic               step_tick;
  logic signed [12:0] diff;
  logic signed [12:0] prod;
  logic [7:0]         scaled;

  assign boundary      = (cnt == 8'd255);
  assign step_tick     = boundary && (step_cnt == STEP_LAST);
  assign pwm_out       = (cnt < duty);
  assign sample_strobe = (cnt == 8'd0);

  // Scale the sample around the 128 midpoint by gain/16 (arithmetic shift floors).
  always_comb begin
    diff   = $signed({5'b0, sample_in}) - 13'sd128;
    prod   = diff * $signed({8'b0, gain});
    // shifted value lies in -128..127, so adding 128 modulo 256 yields 0..255
    scaled = 8'(prod >>> 4) + 8'd128;
  end

  // Period counter, duty reload at each boundary, and fade step divider.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      duty     <= 8'd128;
      step_cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
      if (boundary) begin
        duty <= scaled;
        if (step_tick) step_cnt <= '0;
        else           step_cnt <= step_cnt + 8'd1;
      end
    end
  end

  // Fade state machine: one gain step per step tick toward the mute target.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MUTED;
      gain  <= '0;
      muted <= 1'b1;
    end else if (step_tick) begin
      case (state)
        MUTED: begin
          if (!mute) begin
            state <= FADE_IN;
            gain  <= 5'd1;
            muted <= 1'b0;
          end
        end
        FADE_IN: begin
          if (!mute) begin
            gain <= gain + 5'd1;
            if (gain == 5'd15) state <= PLAY;
          end else begin
            gain <= gain - 5'd1;
            if (gain == 5'd1) begin
              state <= MUTED;
              muted <= 1'b1;
            end else begin
              state <= FADE_OUT;
            end
          end
        end
        PLAY: begin
          if (mute) begin
            state <= FADE_OUT;
            gain  <= 5'd15;
          end
        end
        FADE_OUT: begin
          if (mute) begin
            gain <= gain - 5'd1;
            if (gain == 5'd1) begin
              state <= MUTED;
              muted <= 1'b1;
            end
          end else begin
            gain <= gain + 5'd1;
            // reversing at gain 15 lands on 16, which is PLAY, so gain cannot overshoot
            state <= (gain == 5'd15) ? PLAY : FADE_IN;
          end
        end
        default: begin
          state <= MUTED;
          gain  <= '0;
          muted <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_audio_out.sv
// Self-checking bench for pwm_audio_out: table of duty measurements, directed
// fade/reset sequences, and a randomized run against a behavioural model.
module tb_pwm_audio_out;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] sample_in = 8'd128;
  logic       mute = 1'b1;
  logic       pwm1, str1, mut1;
  logic       pwm3, str3, mut3;

  pwm_audio_out #(.FADE_STEP_PERIODS(1)) dut1 (
    .clk(clk), .reset(reset), .sample_in(sample_in), .mute(mute),
    .pwm_out(pwm1), .sample_strobe(str1), .muted(mut1)
  );

  pwm_audio_out #(.FADE_STEP_PERIODS(3)) dut3 (
    .clk(clk), .reset(reset), .sample_in(sample_in), .mute(mute),
    .pwm_out(pwm3), .sample_strobe(str3), .muted(mut3)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Behavioural model state, one set per instance (index 0: P=1, index 1: P=3)
  int m_cnt[2];
  int m_duty[2];
  int m_gain[2];
  int m_step[2];
  bit m_valid = 1'b0;
  int per[2] = '{1, 3};

  // duty = 128 + floor((s-128)*g/16)
  function automatic int scale(input int s, input int g);
    int v;
    int q;
    v = (s - 128) * g;
    if (v >= 0) q = v / 16;
    else        q = -((-v + 15) / 16);
    return 128 + q;
  endfunction

  // gain walks one step toward 0 (mute) or 16 (unmute), saturating
  function automatic int next_gain(input int g, input logic m);
    if (m) return (g > 0) ? g - 1 : 0;
    return (g < 16) ? g + 1 : 16;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_cnt[k]  <= 0;
        m_duty[k] <= 128;
        m_gain[k] <= 0;
        m_step[k] <= 0;
      end else begin
        m_cnt[k] <= (m_cnt[k] + 1) % 256;
        if (m_cnt[k] == 255) begin
          m_duty[k] <= scale(int'(sample_in), m_gain[k]);
          if (m_step[k] == per[k] - 1) begin
            m_step[k] <= 0;
            m_gain[k] <= next_gain(m_gain[k], mute);
          end else begin
            m_step[k] <= m_step[k] + 1;
          end
        end
      end
    end
    if (reset) m_valid <= 1'b1;
  end

  // Every cycle, compare both instances' outputs to the model
  always @(negedge clk) begin
    logic ap, as, am, ep, es, em;
    if (m_valid) begin
      for (int k = 0; k < 2; k++) begin
        ap = (k == 0) ? pwm1 : pwm3;
        as = (k == 0) ? str1 : str3;
        am = (k == 0) ? mut1 : mut3;
        ep = (m_cnt[k] < m_duty[k]);
        es = (m_cnt[k] == 0);
        em = (m_gain[k] == 0);
        tests++;
        if (ap !== ep || as !== es || am !== em) begin
          fails++;
          $display("FAIL model_p%0d t=%0t cnt=%0d pwm=%b/%b strobe=%b/%b muted=%b/%b (got/expected)",
                   per[k], $time, m_cnt[k], ap, ep, as, es, am, em);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the caller at the negedge of the first cycle with cnt == 0
  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Count dut1 high cycles in period p (period 0 begins right after reset)
  task automatic measure(input int p, output int highs);
    highs = 0;
    for (int i = 0; i < (p + 1) * 256; i++) begin
      if (i >= p * 256 && pwm1) highs++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    int         gain;
    logic [7:0] sample;
    int         exp_high;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int h;
    int n;

    vecs = '{
      '{1,  8'd255, 135}, '{1,  8'd0,   120}, '{1,  8'd127, 127},
      '{8,  8'd255, 191}, '{8,  8'd0,   64},  '{8,  8'd128, 128},
      '{8,  8'd127, 127}, '{16, 8'd0,   0},   '{16, 8'd255, 255},
      '{16, 8'd200, 200}, '{4,  8'd77,  115}, '{12, 8'd129, 128}
    };

    // Duty at a given gain: period g+1 uses the gain held at the boundary before it
    for (int v = 0; v < 12; v++) begin
      mute      = 1'b0;
      sample_in = vecs[v].sample;
      do_reset();
      measure(vecs[v].gain + 1, h);
      check($sformatf("duty_g%0d_s%0d", vecs[v].gain, vecs[v].sample), h, vecs[v].exp_high);
    end

    // Held muted: duty stays at midpoint regardless of sample
    mute      = 1'b1;
    sample_in = 8'd200;
    do_reset();
    check("reset_strobe", int'(str1), 1);
    check("reset_pwm", int'(pwm1), 1);
    check("reset_muted", int'(mut1), 1);
    for (int p = 0; p < 4; p++) begin
      h = 0;
      for (int i = 0; i < 256; i++) begin
        if (pwm1) h++;
        @(negedge clk);
      end
      check($sformatf("muted_period%0d_highs", p), h, 128);
    end
    check("muted_hold", int'(mut1), 1);

    // Reverse mid fade-in at gain 5: five ticks down to MUTED
    mute      = 1'b0;
    sample_in = 8'd255;
    do_reset();
    step(5 * 256);
    mute = 1'b1;
    step(4 * 256);
    check("reverse_gain1_not_muted", int'(mut1), 0);
    step(256);
    check("reverse_muted_after_5", int'(mut1), 1);

    // Step divider of 3: first gain change after the third boundary
    mute = 1'b0;
    do_reset();
    n = 0;
    for (int i = 0; i < 3 * 256; i++) begin
      if (str3) n++;
      if (i == 256) check("p1_unmuted_after_tick", int'(mut1), 0);
      if (i == 2 * 256) check("p3_still_muted_boundary2", int'(mut3), 1);
      @(negedge clk);
    end
    check("p3_strobes_in_768", n, 3);
    check("p3_unmuted_boundary3", int'(mut3), 0);

    // Reset at cnt=100 while in PLAY
    mute = 1'b0;
    do_reset();
    step(17 * 256 + 100);
    check("play_before_reset", int'(mut1), 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_strobe", int'(str1), 1);
    check("midreset_muted", int'(mut1), 1);
    check("midreset_pwm", int'(pwm1), 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!str1 && n < 300);
    check("midreset_next_strobe_cycles", n, 256);

    // Random samples, sporadic mute toggles and one mid-run reset
    do_reset();
    for (int i = 0; i < 12000; i++) begin
      sample_in = 8'($urandom);
      if ($urandom_range(0, 399) == 0) mute = ~mute;
      reset = (i == 7000);
      @(negedge clk);
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pwm_audio_out.md
PWM_AUDIO_OUT -- requirements
Module: pwm_audio_out

Interface
REQ-001 Parameter: FADE_STEP_PERIODS, default 1, number of PWM periods per gain step; legal range 1..255.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 sample_in  input  8  unsigned audio sample (the 8-bit mixed output of the sound card); 128 = silence.
REQ-005 mute  input  1  level request to fade to silence (1) or fade to full volume (0).
REQ-006 pwm_out  output  1  1-bit PWM audio drive to the speaker filter.
REQ-007 sample_strobe  output  1  one-cycle pulse marking the first cycle of each PWM period.
REQ-008 muted  output  1  high while the block is in state MUTED.

Function
REQ-009 Registers: cnt[7:0] period counter, duty[7:0], gain[4:0] (0..16), step_cnt[7:0], 2-bit state.
REQ-010 cnt SHALL increment by 1 every cycle and wrap 255 -> 0; one PWM period = 256 cycles.
REQ-011 A boundary is the cycle where cnt == 255.
REQ-012 pwm_out SHALL be the combinational compare (cnt < duty) of registered values: high for exactly duty cycles per period; duty 0 gives constant low, duty 255 gives 255/256 high.
REQ-013 At each boundary, duty SHALL load scaled = 128 + (((sample_in - 128) * gain) >>> 4), computed signed and at least 12 bits wide, using the gain value held before that edge.
REQ-014 The shift SHALL be arithmetic, rounding toward minus infinity; the result range is 0..255 with no clamp needed.
REQ-015 Between boundaries, duty SHALL hold; sample_in is sampled only at boundaries.
REQ-016 sample_strobe SHALL be 1 exactly in the cycle where cnt == 0, else 0.
REQ-017 step_cnt SHALL increment at each boundary and wrap to 0 after FADE_STEP_PERIODS-1.
REQ-018 A step tick is a boundary where step_cnt == FADE_STEP_PERIODS-1.
REQ-019 Gain and state SHALL change only on step ticks; mute is sampled only on step ticks.
REQ-020 State MUTED (gain 0), step tick with mute=0: go to FADE_IN, gain <= 1.
REQ-021 State MUTED, step tick with mute=1: no change.
REQ-022 FADE_IN, mute=0: gain <= gain+1; when the new gain is 16, go to PLAY on the same edge.
REQ-023 FADE_IN, mute=1: go to FADE_OUT, gain <= gain-1; when the new gain is 0, go to MUTED.
REQ-024 PLAY (gain 16), mute=1: go to FADE_OUT, gain <= 15; with mute=0: no change.
REQ-025 FADE_OUT, mute=1: gain <= gain-1; when the new gain is 0, go to MUTED on the same edge.
REQ-026 FADE_OUT, mute=0: go to FADE_IN, gain <= gain+1.
REQ-027 gain SHALL never leave 0..16; no skipped or repeated steps on direction reversal.
REQ-028 muted SHALL be 1 iff state == MUTED.
REQ-029 A full fade spans 16 step ticks = 16*FADE_STEP_PERIODS periods.

Reset
REQ-030 On reset=1 at a clock edge, the following SHALL load regardless of cnt phase or fade progress: cnt=0, duty=128, gain=0, step_cnt=0, state=MUTED.
REQ-031 Outputs during and in the first cycle after reset SHALL be: pwm_out=1 (0<128), sample_strobe=1, muted=1.
REQ-032 Reset asserted mid-period or mid-fade SHALL leave no residual state; the first boundary occurs 255 cycles after reset deasserts.

Verification
REQ-033 Scenario: reset, mute=1, sample_in=200 for 4 periods -> duty stays 128, pwm_out high 128 of every 256 cycles, muted=1.
REQ-034 Scenario: FADE_STEP_PERIODS=1, mute=0, sample_in=255 -> gain 1..16 over 16 boundaries, duty 135 at gain 1 and 191 at gain 8, duty 255 once gain=16, state PLAY, muted=0 from first tick.
REQ-035 Scenario: at gain 16, sample_in=0 -> duty 0, pwm_out low all period; at gain 8, duty 64; at sample_in=128 and any gain -> duty 128.
REQ-036 Scenario: mute=1 while in FADE_IN at gain 5 -> gain 4,3,2,1,0 on the next 5 ticks, MUTED with muted=1 after the 5th.
REQ-037 Scenario: FADE_STEP_PERIODS=3 -> gain changes only every 768 cycles; sample_strobe pulses every 256 cycles.
REQ-038 Scenario: reset at cnt=100 in PLAY -> next cycle cnt=0, duty=128, gain=0, muted=1, sample_strobe=1.
